// File: rtl/seg7_scan_display.sv
// -----------------------------------------------------------------------------
// seg7_scan_display
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   Shows a 16-bit counter value as four hex digits. The value is latched once
//   per refresh frame so a frame is never torn. After each ripple-carry event,
//   the decimal point of digit 0 flashes for DP_FRAMES frames.
//
//   Parameters
//     SCAN_DIV   clk cycles per digit slot (>= 1)
//     DP_FRAMES  refresh frames the decimal point stays lit per Rc event (>= 1)
//
//   Ports
//     clk    in   system clock, rising edge
//     rst    in   asynchronous reset, active-high
//     cnt    in   [15:0] value to display, digit 0 = cnt[3:0]
//     Rc     in   counter ripple-carry, may be a single-cycle pulse
//     an     out  [3:0] digit enables, active-low, an[0] = rightmost digit
//     seg    out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//     dp     out  decimal point, active-low
//     frame  out  single-cycle pulse at each frame boundary
//
//   Build option
//     LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                            nonzero nibble are blanked. Digit 0 is never
//                            blanked.
// -----------------------------------------------------------------------------
module seg7_scan_display #(
   parameter int SCAN_DIV  = 50000,
   parameter int DP_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cnt,
   input  logic        Rc,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame
);

   localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int HOLD_W = $clog2(DP_FRAMES + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DP_FRAMES);

   // Hex digit to active-low {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      seg_decode = 7'b1111111;
      case (nib)
         4'h0: seg_decode = 7'b1000000;
         4'h1: seg_decode = 7'b1111001;
         4'h2: seg_decode = 7'b0100100;
         4'h3: seg_decode = 7'b0110000;
         4'h4: seg_decode = 7'b0011001;
         4'h5: seg_decode = 7'b0010010;
         4'h6: seg_decode = 7'b0000010;
         4'h7: seg_decode = 7'b1111000;
         4'h8: seg_decode = 7'b0000000;
         4'h9: seg_decode = 7'b0010000;
         4'hA: seg_decode = 7'b0001000;
         4'hB: seg_decode = 7'b0000011;
         4'hC: seg_decode = 7'b1000110;
         4'hD: seg_decode = 7'b0100001;
         4'hE: seg_decode = 7'b0000110;
         4'hF: seg_decode = 7'b0001110;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   // State
   logic [DIV_W-1:0]  div;
   logic [1:0]        idx;
   logic [15:0]       snap;
   logic              rc_flag;
   logic [HOLD_W-1:0] dp_hold;

   // Next-state values
   logic              tick;
   logic              boundary;
   logic [DIV_W-1:0]  div_next;
   logic [1:0]        idx_next;
   logic [15:0]       snap_next;
   logic              rc_next;
   logic [HOLD_W-1:0] hold_next;
   logic [3:0]        nibble;
   logic              blank;
   logic [3:0]        an_next;
   logic [6:0]        seg_next;
   logic              dp_next;

   // NOTE: every signal assigned in this always_comb gets a value on every
   // path (defaults first), otherwise synthesis infers a latch.
   always_comb begin
      tick      = (div == DIV_LAST);
      boundary  = tick && (idx == 2'd3);
      div_next  = tick ? '0 : div + 1'b1;
      // 2-bit index wraps 3 -> 0 on its own.
      idx_next  = tick ? idx + 2'd1 : idx;
      snap_next = boundary ? cnt : snap;

      // An Rc on the boundary cycle itself re-arms the flag, so that event
      // is serviced one frame later instead of being lost.
      rc_next   = Rc | (rc_flag & ~boundary);

      hold_next = dp_hold;
      if (boundary) begin
         if (rc_flag) begin
            hold_next = HOLD_LOAD;
         end else if (dp_hold != '0) begin
            hold_next = dp_hold - 1'b1;
         end
      end

      // Outputs are computed from the post-edge index and snapshot so they
      // move on the same edge as idx and show freshly latched data on a wrap.
      nibble = snap_next[3:0];
      case (idx_next)
         2'd0: nibble = snap_next[3:0];
         2'd1: nibble = snap_next[7:4];
         2'd2: nibble = snap_next[11:8];
         2'd3: nibble = snap_next[15:12];
         default: nibble = snap_next[3:0];
      endcase

      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      case (idx_next)
         2'd1: blank = (snap_next[15:4]  == 12'h000);
         2'd2: blank = (snap_next[15:8]  == 8'h00);
         2'd3: blank = (snap_next[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
`endif

      an_next  = blank ? 4'b1111 : ~(4'b0001 << idx_next);
      seg_next = blank ? 7'b1111111 : seg_decode(nibble);
      dp_next  = blank | ~((idx_next == 2'd0) && (hold_next != '0));
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div     <= '0;
         idx     <= 2'd0;
         snap    <= 16'h0000;
         rc_flag <= 1'b0;
         dp_hold <= '0;
         an      <= 4'b1110;
         seg     <= 7'b1000000;
         dp      <= 1'b1;
         frame   <= 1'b0;
      end else begin
         div     <= div_next;
         idx     <= idx_next;
         snap    <= snap_next;
         rc_flag <= rc_next;
         dp_hold <= hold_next;
         an      <= an_next;
         seg     <= seg_next;
         dp      <= dp_next;
         frame   <= boundary;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_display
//   Self-checking bench for seg7_scan_display with SCAN_DIV=4, DP_FRAMES=2.
//   The reference model works from elapsed clock edges since reset: slot,
//   frame boundaries, the latched value and the decimal-point windows are all
//   derived arithmetically from that count and the stimulus history.
// -----------------------------------------------------------------------------
module tb_seg7_scan_display;

   localparam int SD  = 4;
   localparam int DPF = 2;
   localparam int FR  = 4 * SD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cnt = 16'h0000;
   logic        Rc  = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame;

   seg7_scan_display #(.SCAN_DIV(SD), .DP_FRAMES(DPF)) dut (
      .clk   (clk),
      .rst   (rst),
      .cnt   (cnt),
      .Rc    (Rc),
      .an    (an),
      .seg   (seg),
      .dp    (dp),
      .frame (frame)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   int          e;        // clock edges since reset release
   logic [15:0] m_snap;   // value latched at the latest frame boundary
   int          svc[$];   // boundary edges at which Rc events start a dp window

   logic [6:0] hex_tab [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic bit lit(int ee);
      foreach (svc[i]) begin
         if (svc[i] <= ee && ee < svc[i] + DPF * FR) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s at edge %0d: observed %b expected %b", tag, e, got, exp);
      end
   endtask

   task automatic check_outputs();
      int         idx;
      bit         blank;
      logic [3:0] nib;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      logic       exp_frame;
      idx   = (e / SD) % 4;
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (idx != 0) && ((m_snap >> (4 * idx)) == 16'h0000);
`endif
      nib       = 4'((m_snap >> (4 * idx)) & 16'h000F);
      exp_an    = blank ? 4'b1111 : (4'b1111 & ~(4'b0001 << idx));
      exp_seg   = blank ? 7'b1111111 : hex_tab[nib];
      exp_dp    = blank ? 1'b1 : !(idx == 0 && lit(e));
      exp_frame = (e > 0) && (e % FR == 0);
      check("an",    {3'b000, an},    {3'b000, exp_an});
      check("seg",   seg,             exp_seg);
      check("dp",    {6'b0, dp},      {6'b0, exp_dp});
      check("frame", {6'b0, frame},   {6'b0, exp_frame});
   endtask

   task automatic reset_model();
      e      = 0;
      m_snap = 16'h0000;
      svc.delete();
   endtask

   // One clock edge: update the model with the inputs sampled at that edge,
   // then compare 1 time unit later. Inputs are changed only after return.
   task automatic step();
      @(posedge clk);
      e++;
      if (Rc) svc.push_back((e / FR + 1) * FR);
      if (e % FR == 0) m_snap = cnt;
      #1;
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Advance until the model edge count is at the given position in a frame.
   task automatic run_to(input int phase);
      for (int i = 0; i < FR && (e % FR) != phase; i++) step();
   endtask

   initial begin
      reset_model();

      // Reset state while clocking with reset held
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      cnt = 16'h1A3F;
      rst = 1'b0;

      // Steady display of 1A3F across several frames
      run(3 * FR);

      // Change cnt during the idx=1 slot: must not appear until next boundary
      run_to(5);
      cnt = 16'h1A40;
      run(2 * FR);

      // Single-cycle Rc mid-frame
      run_to(6);
      Rc = 1'b1;
      step();
      Rc = 1'b0;
      run(4 * FR);

      // Second Rc during an active hold restarts the count
      run_to(3);
      Rc = 1'b1;
      step();
      Rc = 1'b0;
      run(FR + 4);
      Rc = 1'b1;
      step();
      Rc = 1'b0;
      run(4 * FR);

      // Rc exactly on the frame-boundary edge
      run_to(FR - 1);
      Rc = 1'b1;
      step();
      Rc = 1'b0;
      run(4 * FR);

      // Leading-zero case
      cnt = 16'h0005;
      run(3 * FR);

      // Randomized stimulus
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) cnt = 16'($urandom);
         Rc = ($urandom_range(0, 39) == 0);
         step();
      end
      Rc = 1'b0;

      // Asynchronous reset mid-frame, between clock edges
      run_to(7);
      #2;
      rst = 1'b1;
      #1;
      reset_model();
      check_outputs();
      repeat (2) begin
         @(posedge clk);
         #1;
         check_outputs();
      end
      rst = 1'b0;

      // Random run after reset, including sparse-value patterns
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 3))
               0: cnt = 16'h0000;
               1: cnt = 16'($urandom_range(0, 15));
               2: cnt = 16'($urandom_range(0, 255));
               default: cnt = 16'($urandom);
            endcase
         end
         Rc = ($urandom_range(0, 29) == 0);
         step();
      end
      Rc = 1'b0;
      run(3 * FR);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
